// File: rtl/ldpc_cnu_pkg.sv
// Shared types and default sizes for the LDPC check-node unit datapath.
package ldpc_cnu_pkg;

    localparam int unsigned CN_DEGREE_DEF = 8;
    localparam int unsigned QUAN_SIZE_DEF = 4;
    localparam int unsigned IDX_W_DEF     = $clog2(CN_DEGREE_DEF);

    typedef enum logic {
        IDLE,
        EXPAND
    } cnu_state_e;

    // Compressed check-node record at the default code geometry.
    typedef struct packed {
        logic [QUAN_SIZE_DEF-1:0] m1;
        logic [QUAN_SIZE_DEF-1:0] m2;
        logic [IDX_W_DEF-1:0]     min_index;
        logic                     sign_total;
        logic [CN_DEGREE_DEF-1:0] sign_vec;
    } cnu_rec_t;

endpackage

// File: rtl/cnu_msg_expander_c2v_fmt.sv
// Converts a C2V sign/magnitude pair to the output message format.
// C2V_TWOS_COMP_EN selects two's complement; otherwise sign-magnitude {sign, mag}.
module c2v_fmt
    import ldpc_cnu_pkg::*;
#(
    parameter int unsigned QUAN_SIZE = QUAN_SIZE_DEF
) (
    input  logic                 sign,
    input  logic [QUAN_SIZE-1:0] mag,
    output logic [QUAN_SIZE:0]   msg
);

`ifdef C2V_TWOS_COMP_EN
    // Negating a zero magnitude yields zero, so a negative zero never appears.
    always_comb msg = sign ? -{1'b0, mag} : {1'b0, mag};
`else
    always_comb msg = {sign, mag};
`endif

endmodule

// File: rtl/cnu_msg_expander.sv
// Check-node message expander: buffers compressed CN records (2 entries) and emits one C2V
// message per edge per cycle. Output format chosen by C2V_TWOS_COMP_EN (see c2v_fmt).
module cnu_msg_expander
    import ldpc_cnu_pkg::*;
#(
    parameter int unsigned CN_DEGREE = CN_DEGREE_DEF,
    parameter int unsigned QUAN_SIZE = QUAN_SIZE_DEF,
    parameter int unsigned IDX_W     = $clog2(CN_DEGREE)
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [QUAN_SIZE-1:0] in_m1,
    input  logic [QUAN_SIZE-1:0] in_m2,
    input  logic [IDX_W-1:0]     in_min_index,
    input  logic                 in_sign_total,
    input  logic [CN_DEGREE-1:0] in_sign_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [QUAN_SIZE:0]   out_msg,
    output logic [IDX_W-1:0]     out_edge,
    output logic                 out_last,
    output logic                 idx_err
);

    localparam int unsigned      LOG_DEG   = $clog2(CN_DEGREE);
    localparam logic [IDX_W-1:0] LAST_EDGE = IDX_W'(CN_DEGREE - 1);

    typedef struct packed {
        logic [QUAN_SIZE-1:0] m1;
        logic [QUAN_SIZE-1:0] m2;
        logic [IDX_W-1:0]     min_index;
        logic                 sign_total;
        logic [CN_DEGREE-1:0] sign_vec;
    } rec_t;

    rec_t                 rec_mem_q [2];
    rec_t                 in_rec;
    rec_t                 head_rec;
    rec_t                 next_rec;
    rec_t                 load_rec;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic                 in_ready_q;
    cnu_state_e           state_q;
    cnu_state_e           state_d;
    logic [IDX_W-1:0]     edge_q;
    logic [IDX_W-1:0]     edge_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [QUAN_SIZE:0]   out_msg_q;
    logic [QUAN_SIZE:0]   fmt_msg;
    logic                 out_last_q;
    logic                 idx_err_q;
    logic                 accept;
    logic                 fire;
    logic                 retire;
    logic                 load;
    logic                 idx_oor;
    logic [QUAN_SIZE-1:0] sel_mag;
    logic                 sel_sign;

    always_comb begin
        in_rec.m1         = in_m1;
        in_rec.m2         = in_m2;
        in_rec.min_index  = in_min_index;
        in_rec.sign_total = in_sign_total;
        in_rec.sign_vec   = in_sign_vec;
    end

    // Only reachable when IDX_W is wider than the edge index of the configured degree.
    if (IDX_W > LOG_DEG) begin : g_oor
        assign idx_oor = |in_min_index[IDX_W-1:LOG_DEG];
    end else begin : g_no_oor
        assign idx_oor = 1'b0;
    end

    assign accept   = in_valid && in_ready_q;
    assign fire     = out_valid_q && out_ready;
    assign retire   = fire && (edge_q == LAST_EDGE);
    assign head_rec = rec_mem_q[rd_ptr_q];
    // With one entry held, the follower is the record being accepted this very cycle.
    assign next_rec = (count_q == 2'd2) ? rec_mem_q[~rd_ptr_q] : in_rec;

    always_comb begin
        count_d = count_q;
        case ({accept, retire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        edge_d      = edge_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        load_rec    = head_rec;
        unique case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    state_d     = EXPAND;
                    edge_d      = '0;
                    out_valid_d = 1'b1;
                    load        = 1'b1;
                end
            end
            EXPAND: begin
                if (fire) begin
                    if (edge_q == LAST_EDGE) begin
                        edge_d = '0;
                        if ((count_q == 2'd2) || accept) begin
                            load     = 1'b1;
                            load_rec = next_rec;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        edge_d = edge_q + 1'b1;
                        load   = 1'b1;
                    end
                end
            end
        endcase
    end

    // An out-of-range min_index never matches an edge, so every edge falls back to m1.
    assign sel_mag  = (edge_d == load_rec.min_index) ? load_rec.m2 : load_rec.m1;
    assign sel_sign = load_rec.sign_total ^ load_rec.sign_vec[edge_d[LOG_DEG-1:0]];

    c2v_fmt #(
        .QUAN_SIZE(QUAN_SIZE)
    ) u_c2v_fmt (
        .sign(sel_sign),
        .mag (sel_mag),
        .msg (fmt_msg)
    );

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            rec_mem_q[wr_ptr_q] <= in_rec;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
            edge_q      <= '0;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_last_q  <= 1'b0;
            idx_err_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            in_ready_q  <= (count_d != 2'd2);
            state_q     <= state_d;
            edge_q      <= edge_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (retire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (load) begin
                out_msg_q  <= fmt_msg;
                out_last_q <= (edge_d == LAST_EDGE);
            end
            if (accept && idx_oor) begin
                idx_err_q <= 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_edge  = edge_q;
    assign out_last  = out_last_q;
    assign idx_err   = idx_err_q;

endmodule

// File: tb/tb_cnu_msg_expander.sv
// Bench for cnu_msg_expander: vector table, back-to-back, random backpressure, reset and
// out-of-range min_index on a CN_DEGREE=4 instance. Honours C2V_TWOS_COMP_EN for expectations.
module tb_cnu_msg_expander;
    import ldpc_cnu_pkg::*;

    typedef struct {
        cnu_rec_t    rec;
        logic [7:0]  exp_sign;
        logic [31:0] exp_mag;
    } vec_t;

    typedef struct {
        logic [4:0] msg;
        logic [2:0] edge_idx;
        logic       last;
    } exp_t;

`ifdef C2V_TWOS_COMP_EN
    localparam logic [4:0] EXP_NEG3    = 5'b11101;
    localparam logic [4:0] EXP_NEGZERO = 5'b00000;
`else
    localparam logic [4:0] EXP_NEG3    = 5'b10011;
    localparam logic [4:0] EXP_NEGZERO = 5'b10000;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_m1;
    logic [3:0] in_m2;
    logic [2:0] in_min_index;
    logic       in_sign_total;
    logic [7:0] in_sign_vec;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_msg;
    logic [2:0] out_edge;
    logic       out_last;
    logic       idx_err;

    logic       d4_in_valid;
    logic       d4_in_ready;
    logic [3:0] d4_m1;
    logic [3:0] d4_m2;
    logic [2:0] d4_idx;
    logic       d4_st;
    logic [3:0] d4_sv;
    logic       d4_out_valid;
    logic       d4_out_ready;
    logic [4:0] d4_out_msg;
    logic [2:0] d4_out_edge;
    logic       d4_out_last;
    logic       d4_idx_err;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t e;
    logic stall_prev = 1'b0;
    logic [31:0] held;
    logic sends_done;
    vec_t vecs[4];

    always #5 clk = ~clk;

    cnu_msg_expander u_dut (
        .sys_clk      (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_m1        (in_m1),
        .in_m2        (in_m2),
        .in_min_index (in_min_index),
        .in_sign_total(in_sign_total),
        .in_sign_vec  (in_sign_vec),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_msg      (out_msg),
        .out_edge     (out_edge),
        .out_last     (out_last),
        .idx_err      (idx_err)
    );

    cnu_msg_expander #(
        .CN_DEGREE(4),
        .QUAN_SIZE(4),
        .IDX_W    (3)
    ) u_dut4 (
        .sys_clk      (clk),
        .rst          (rst),
        .in_valid     (d4_in_valid),
        .in_ready     (d4_in_ready),
        .in_m1        (d4_m1),
        .in_m2        (d4_m2),
        .in_min_index (d4_idx),
        .in_sign_total(d4_st),
        .in_sign_vec  (d4_sv),
        .out_valid    (d4_out_valid),
        .out_ready    (d4_out_ready),
        .out_msg      (d4_out_msg),
        .out_edge     (d4_out_edge),
        .out_last     (d4_out_last),
        .idx_err      (d4_idx_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] fmt(input logic s, input logic [3:0] m);
`ifdef C2V_TWOS_COMP_EN
        int v;
        logic [31:0] w;
        v = s ? -int'(m) : int'(m);
        w = v;
        return w[4:0];
`else
        return {s, m};
`endif
    endfunction

    function automatic vec_t mk(input logic [3:0] m1, input logic [3:0] m2, input logic [2:0] idx,
                                input logic st, input logic [7:0] sv, input logic [7:0] es,
                                input logic [31:0] em);
        vec_t v;
        v.rec.m1         = m1;
        v.rec.m2         = m2;
        v.rec.min_index  = idx;
        v.rec.sign_total = st;
        v.rec.sign_vec   = sv;
        v.exp_sign       = es;
        v.exp_mag        = em;
        return v;
    endfunction

    function automatic cnu_rec_t rec(input logic [3:0] m1, input logic [3:0] m2,
                                     input logic [2:0] idx, input logic st, input logic [7:0] sv);
        cnu_rec_t r;
        r.m1 = m1; r.m2 = m2; r.min_index = idx; r.sign_total = st; r.sign_vec = sv;
        return r;
    endfunction

    // Reference: a record expands into 8 messages in edge order, straight from the edge rule.
    task automatic model_push(input logic [3:0] m1, input logic [3:0] m2, input logic [2:0] idx,
                              input logic st, input logic [7:0] sv);
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            x.msg      = fmt(st ^ sv[i], (i == int'(idx)) ? m2 : m1);
            x.edge_idx = 3'(i);
            x.last     = (i == 7);
            exp_q.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {22'd0, out_valid, out_last, out_edge, out_msg}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_msg: got edge %0d msg 0x%0h, expected no message",
                             out_edge, out_msg);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_msg", {23'd0, out_last, out_edge, out_msg},
                          {23'd0, e.last, e.edge_idx, e.msg});
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {22'd0, out_valid, out_last, out_edge, out_msg};
            if (in_valid && in_ready) begin
                model_push(in_m1, in_m2, in_min_index, in_sign_total, in_sign_vec);
            end
        end
    end

    task automatic send(input cnu_rec_t r, output int waits);
        logic acc;
        waits         = 0;
        in_valid      = 1'b1;
        in_m1         = r.m1;
        in_m2         = r.m2;
        in_min_index  = r.min_index;
        in_sign_total = r.sign_total;
        in_sign_vec   = r.sign_vec;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w3;
        int n;
        int bad;
        cnu_rec_t r;

        vecs[0] = mk(4'd3, 4'd5,  3'd2, 1'b1, 8'b0000_0101, 8'b1111_1010, 32'h3333_3533);
        vecs[1] = mk(4'd0, 4'd15, 3'd0, 1'b0, 8'b1000_0001, 8'b1000_0001, 32'h0000_000F);
        vecs[2] = mk(4'd7, 4'd9,  3'd7, 1'b1, 8'hFF,        8'h00,        32'h9777_7777);
        vecs[3] = mk(4'd1, 4'd2,  3'd4, 1'b1, 8'hA5,        8'h5A,        32'h1112_1111);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_m1 = '0; in_m2 = '0; in_min_index = '0; in_sign_total = 1'b0; in_sign_vec = '0;
        d4_in_valid = 1'b0; d4_out_ready = 1'b1;
        d4_m1 = '0; d4_m2 = '0; d4_idx = '0; d4_st = 1'b0; d4_sv = '0;
        sends_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_msg", out_msg, 0);
        check("rst_out_edge", out_edge, 0);
        check("rst_out_last", out_last, 0);
        check("rst_idx_err", idx_err, 0);

        // Table: one record at a time from idle, every edge checked in place.
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].rec, w);
            check("tbl_latency", out_valid, 0);
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("tbl%0d_edge%0d", v, k),
                      {22'd0, out_valid, out_last, out_edge, out_msg},
                      {22'd0, 1'b1, 1'(k == 7), 3'(k),
                       fmt(vecs[v].exp_sign[k], vecs[v].exp_mag[4*k +: 4])});
            end
            @(posedge clk);
            #1;
            check("tbl_idle_after", out_valid, 0);
        end

        // Negative values in the output format, including negative zero.
        send(rec(4'd3, 4'd3, 3'd0, 1'b1, 8'h00), w);
        @(posedge clk);
        #1;
        check("fmt_neg3", out_msg, EXP_NEG3);
        repeat (8) @(posedge clk);
        #1;
        send(rec(4'd0, 4'd0, 3'd0, 1'b1, 8'h00), w);
        @(posedge clk);
        #1;
        check("fmt_negzero", out_msg, EXP_NEGZERO);
        repeat (8) @(posedge clk);
        #1;

        // Three records back to back: third stalls a full record, stream has no gaps.
        fork
            begin
                send(rec(4'd2, 4'd6, 3'd1, 1'b0, 8'h3C), w);
                send(rec(4'd5, 4'd1, 3'd6, 1'b1, 8'h81), w);
                check("b2b_second_waits", 32'(w), 0);
                send(rec(4'd9, 4'd4, 3'd3, 1'b0, 8'hF0), w3);
                check("b2b_third_waits", 32'(w3), 8);
            end
            begin
                n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                bad = 0;
                for (int k = 0; k < 24; k++) begin
                    if (!out_valid || out_edge != 3'(k % 8)) bad++;
                    @(posedge clk);
                    #1;
                end
                check("b2b_stream_gaps", 32'(bad), 0);
                check("b2b_end_idle", out_valid, 0);
            end
        join

        // Random records under random backpressure; the monitor checks content and stalls.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    r.m1         = 4'($urandom_range(0, 15));
                    r.m2         = 4'($urandom_range(0, 15));
                    r.min_index  = 3'($urandom_range(0, 7));
                    r.sign_total = 1'($urandom_range(0, 1));
                    r.sign_vec   = 8'($urandom());
                    send(r, w);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #0;
                end
                sends_done = 1'b1;
            end
            begin
                for (int c = 0; c < 4000; c++) begin
                    if (sends_done && exp_q.size() == 0) break;
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        check("rand_drain", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        check("rand_idle", out_valid, 0);
        check("rand_no_idx_err", idx_err, 0);
        repeat (2) @(posedge clk);
        #1;

        // CN_DEGREE=4 instance: out-of-range min_index gives m1 on every edge, sticky flag.
        d4_m1 = 4'd2; d4_m2 = 4'd6; d4_idx = 3'd7; d4_st = 1'b0; d4_sv = 4'b0110;
        d4_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d4_in_valid = 1'b0;
        check("d4_latency", d4_out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("d4_oor_edge%0d", k),
                  {22'd0, d4_out_valid, d4_out_last, d4_out_edge, d4_out_msg},
                  {22'd0, 1'b1, 1'(k == 3), 3'(k), fmt(d4_sv[k], 4'd2)});
        end
        check("d4_idx_err_set", d4_idx_err, 1);
        @(posedge clk);
        #1;
        d4_m1 = 4'd1; d4_m2 = 4'd4; d4_idx = 3'd1; d4_st = 1'b1; d4_sv = 4'b0000;
        d4_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d4_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("d4_good_edge%0d", k), {27'd0, d4_out_msg},
                  {27'd0, fmt(1'b1, (k == 1) ? 4'd4 : 4'd1)});
        end
        check("d4_idx_err_sticky", d4_idx_err, 1);
        repeat (2) @(posedge clk);
        #1;

        // Reset at edge 3 with a second record queued.
        send(rec(4'd4, 4'd8, 3'd5, 1'b1, 8'h0F), w);
        send(rec(4'd6, 4'd2, 3'd0, 1'b0, 8'hAA), w);
        n = 0;
        while (!(out_valid && out_edge == 3'd3) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_reach_edge3", out_edge, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_edge", out_edge, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_out_msg", out_msg, 0);
        check("midrst_d4_idx_err", d4_idx_err, 0);
        send(rec(4'd3, 4'd7, 3'd6, 1'b0, 8'h40), w);
        check("post_rst_accept", 32'(w), 0);
        @(posedge clk);
        #1;
        check("post_rst_edge0", {23'd0, out_valid, out_edge, out_msg},
              {23'd0, 1'b1, 3'd0, fmt(1'b0, 4'd3)});
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_flushed", out_valid, 0);
        check("post_rst_drain", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cnu_msg_expander.md
# cnu_msg_expander

Check-node message expander for the layered LDPC decoder. It accepts one compressed check-node record per layer slot: min1, min2, min_index, total sign and per-edge signs, as produced by the CNU min-finder plus sign logic. It then serially regenerates the CN_DEGREE check-to-variable (C2V) messages, one edge per cycle, toward the VNU/memory write path. A 2-entry record buffer decouples the CNU side from the C2V consumer, so records stream with no bubbles.

## Interface
- CN_DEGREE, 8, edges per check node; power of two, 4..16
- QUAN_SIZE, 4, magnitude width of m1/m2 and of output magnitude
- IDX_W, $clog2(CN_DEGREE), width of min_index and edge index
- sys_clk  input  1  clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  compressed record present
- in_ready  output  1  buffer has a free entry
- in_m1  input  QUAN_SIZE  smallest (scaled) magnitude
- in_m2  input  QUAN_SIZE  second (scaled/offset) magnitude
- in_min_index  input  IDX_W  edge holding min1
- in_sign_total  input  1  XOR of all edge signs
- in_sign_vec  input  CN_DEGREE  per-edge V2C sign, bit i = edge i
- out_valid  output  1  C2V message valid
- out_ready  input  1  consumer accepts message
- out_msg  output  QUAN_SIZE+1  C2V message (format per Configuration)
- out_edge  output  IDX_W  edge index of out_msg
- out_last  output  1  final edge (CN_DEGREE-1) of the record
- idx_err  output  1  sticky: a record arrived with in_min_index >= CN_DEGREE

## Operation
- Input handshake: a record is accepted on a cycle with in_valid && in_ready; it is written to the buffer tail entry.
- Buffer: 2 entries, with a write pointer, a read pointer and a count of 0..2. in_ready = (count != 2), a registered signal. An accept and a record retire in the same cycle leave count unchanged.
- FSM states:
  - IDLE: count==0 or no record loaded. Moves to EXPAND when count>0; edge_cnt is cleared to 0.
  - EXPAND: the head record is expanded. edge_cnt advances on each out_valid && out_ready.
  - At edge_cnt==CN_DEGREE-1 with handshake, the head record retires (read pointer toggles, count decrements). If another record is buffered, or is being accepted that cycle, the FSM stays in EXPAND with edge_cnt=0. Otherwise it goes to IDLE.
- Per-edge message for edge i:
  - magnitude = (i == min_index) ? m2 : m1
  - sign = sign_total ^ sign_vec[i]
- Out-of-range min_index: every edge gets m1, and idx_err is set (sticky until rst).
- Output register: out_msg, out_edge, out_last and out_valid are registered. They must hold stable while out_valid && !out_ready.
- No arithmetic beyond selection and XOR; there is no width growth on magnitudes.

## Timing
- Reset values: in_ready=1, out_valid=0, out_msg=0, out_edge=0, out_last=0, idx_err=0, count=0, FSM=IDLE.
- Latency: a record accepted at cycle N gives its edge 0 on out_valid at cycle N+1, when the buffer was empty.
- Throughput: 1 message/cycle with out_ready held high. Consecutive records are back-to-back: edge 0 of record k+1 follows edge CN_DEGREE-1 of record k directly.
- Record rate: the sustained input rate is 1 record per CN_DEGREE cycles. With count==2, in_ready deasserts until the head retires; in_ready reasserts the cycle after retirement.
- Backpressure: out_ready low freezes edge_cnt and the output register. Input accepts continue while count<2.
- rst mid-operation: the buffer is flushed, the partially emitted record is discarded, and all outputs take their reset values on the next edge.

## Configuration
- C2V_TWOS_COMP_EN defined: out_msg is QUAN_SIZE+1-bit two's complement, equal to sign ? -{1'b0,mag} : {1'b0,mag}. A zero magnitude with sign=1 outputs 0.
- C2V_TWOS_COMP_EN undefined: out_msg is sign-magnitude, {sign, mag}.
- Handshake and timing are identical in both builds.

## Structure
- Shared package ldpc_cnu_pkg:
  - record typedef cnu_rec_t (m1, m2, min_index, sign_total, sign_vec)
  - FSM state enum {IDLE, EXPAND}
  - constants CN_DEGREE_DEF=8 and QUAN_SIZE_DEF=4
- One sub-module, c2v_fmt: combinational sign/magnitude-to-output format conversion, which contains the macro-dependent logic.
- Buffer, pointers and FSM stay in the top module.

## Test plan
- Single record, m1=3, m2=5, min_index=2, sign_total=1, sign_vec=8'b0000_0101, out_ready=1 → edges 0..7 over 8 consecutive cycles starting N+1. Expected in sign-magnitude (sign,mag):
  - edge 0: (0,3)
  - edge 1: (1,3)
  - edge 2: (0,5)
  - edges 3..7: (1,3)
  - out_last only on edge 7
- Three records presented back-to-back → the third sees in_ready=0 until the first retires. The output stream has 24 messages with no idle cycle between records.
- out_ready toggled pseudo-randomly (~50%) → no message is lost or duplicated, outputs stay stable during stalls, and edge order is 0..7 per record.
- min_index=7 with CN_DEGREE=4 build → all 4 edges carry m1, and idx_err=1 persists across later good records until rst.
- rst asserted at edge 3 of a record with one record queued → the next cycle shows out_valid=0, in_ready=1 and count=0. A fresh record then starts at edge 0.
- C2V_TWOS_COMP_EN build, m1=3 with sign=1 → out_msg=5'b11101; m1=0 with sign=1 → out_msg=0.
